adder32_error_monitor: RTL and testbench
========================================

// Module: adder32_error_monitor
// PURPOSE
//  Sits directly downstream of a 32-bit (approximate) adder and consumes its operands and 33-bit result.
//  Recomputes the exact sum internally and forms error distance ED = |exact - result_i|.
//  Over a window of WINDOW accepted samples it accumulates error statistics for characterising approximate adders:
//  - error count
//  - maximum ED
//  - saturating ED sum
// PARAMETERS
//  WIDTH   32    operand width; result_i and ED are WIDTH+1 bits
//  WINDOW  1024  samples per measurement window (>=1)
//  SUM_W   48    width of ED accumulator (>= WIDTH+1)
// PORTS
//  clk_i        in   1          clock, all state on rising edge
//  rst_ni       in   1          asynchronous reset, active low
//  start_i      in   1          begin new window (honoured in IDLE/DONE only)
//  valid_i      in   1          sample valid from upstream adder stage
//  ready_o      out  1          sample accepted when valid_i & ready_o
//  add1_i       in   WIDTH      operand A fed to the adder under test
//  add2_i       in   WIDTH      operand B fed to the adder under test
//  result_i     in   WIDTH+1    adder-under-test result for add1_i/add2_i
//  busy_o       out  1          window in progress
//  done_o       out  1          statistics final and stable
//  err_count_o  out  $clog2(WINDOW+1)  samples with ED != 0
//  max_ed_o     out  WIDTH+1    largest ED in window
//  sum_ed_o     out  SUM_W      sum of ED, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_ni=0)
//  - state=IDLE; all outputs 0, incl. ready_o, busy_o and done_o.
//  Arithmetic
//  - exact = {1'b0,add1_i} + {1'b0,add2_i} (WIDTH+1 bits).
//  - ED = exact>=result_i ? exact-result_i : result_i-exact (unsigned, WIDTH+1 bits).
//  FSM IDLE -> RUN -> DONE
//  - IDLE: ready_o=0. start_i -> RUN; clear stats; remaining=WINDOW.
//  - RUN: busy_o=1; ready_o=1 while remaining!=0.
//    - Each accept decrements remaining and updates stats.
//    - ready_o drops the cycle after the last accept.
//    - start_i is ignored.
//  - DONE: done_o=1; stats held.
//    - start_i restarts as in IDLE (stats cleared on that edge, done_o falls).
//  - valid_i outside RUN, or with ready_o=0, is ignored (no state change).
//  Stats update
//  - err_count += (ED!=0).
//  - max_ed = max(max_ed, ED).
//  - sum_ed = min(sum_ed+ED, 2^SUM_W-1).
//  Latency
//  - Stats reflect an accepted sample 1 cycle after its accept edge.
//  - RUN->DONE one cycle after the last stats update.
//  - Throughput is 1 sample/cycle.
//  Boundaries
//  - WINDOW=1: single accept.
//  - ED = 2^WIDTH (carry-out lost) is valid and becomes max_ed.
//  - Back-to-back windows: start_i in the DONE cycle means no idle cycle.
// CONFIGURATION
//  ADDER32_ERRMON_PIPE_EN
//  - Defined: exact/ED registered in a stage before accumulation.
//    - Stats update 2 cycles after accept; DONE one cycle later.
//    - The pipeline register is flushed by reset and by start_i.
//  - Undefined: ED is combinational from inputs; 1-cycle stats latency as above.
// STRUCTURE
//  Package adder32_errmon_pkg:
//  - state encoding localparams (IDLE/RUN/DONE)
//  - ED width function (WIDTH+1)
//  - saturating-add helper
//  Sub-module adder32_abs_diff: exact-sum and |a-b| ED unit, pure combinational; instanced once.
//  Top: FSM, remaining counter, three accumulators, optional ED pipe register.
// TESTING
//  1. WINDOW=4, exact result_i every sample -> done_o, err_count 0, max_ed 0, sum_ed 0.
//  2. add1=29AF2430, add2=7A1B9ABC, result_i=0_A3CABEE7 -> ED=5.
//     Alongside 3 exact samples -> err_count 1, max 5, sum 5.
//  3. add1=FFFFFFFF, add2=00000001, result_i=0 -> ED=1_00000000 = max_ed_o; err_count 1.
//  4. SUM_W=33, 4x ED=1_00000000 -> sum_ed_o = 1_FFFFFFFF (saturated).
//  5. valid_i gapped, and held high after last accept -> exactly WINDOW accepted; ready_o=0 in DONE.
//  6. rst_ni low mid-RUN -> outputs 0 immediately.
//     Then start_i in DONE with valid_i -> stats cleared, no valid ignored-sample leakage.
//  Run all with and without ADDER32_ERRMON_PIPE_EN; check latency shift.

Source files
------------

// File: rtl/adder32_errmon_pkg.sv
// adder32_errmon_pkg: state encoding and arithmetic helpers
// shared by the adder32 error monitor.
package adder32_errmon_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   function automatic int ed_w(input int w);
      return w + 1;
   endfunction

   // Unsigned add clamped to the all-ones value of a w-bit field (w <= 64).
   function automatic logic [63:0] sat_add(
      input logic [63:0] a,
      input logic [63:0] b,
      input int unsigned w
   );
      logic [64:0] s;
      logic [64:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (s > lim) ? lim[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/adder32_abs_diff.sv
// adder32_abs_diff: exact sum of two operands and the unsigned
// distance between that sum and the result under test.
module adder32_abs_diff
   import adder32_errmon_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   input  logic [WIDTH:0]   i_result,
   output logic [WIDTH:0]   o_ed
);

   localparam int EDW = ed_w(WIDTH);

   logic [EDW-1:0] w_exact;

   assign w_exact = {1'b0, i_add1} + {1'b0, i_add2};
   assign o_ed    = (w_exact >= i_result) ? (w_exact - i_result)
                                          : (i_result - w_exact);

endmodule

// File: rtl/adder32_error_monitor.sv
// adder32_error_monitor: windowed error statistics for an approximate adder.
// Define ADDER32_ERRMON_PIPE_EN to register ED before accumulation.
module adder32_error_monitor
   import adder32_errmon_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int WINDOW = 1024,
   parameter int SUM_W  = 48
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [WIDTH-1:0]             add1_i,
   input  logic [WIDTH-1:0]             add2_i,
   input  logic [WIDTH:0]               result_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(WINDOW+1)-1:0]  err_count_o,
   output logic [WIDTH:0]               max_ed_o,
   output logic [SUM_W-1:0]             sum_ed_o
);

   localparam int EDW   = ed_w(WIDTH);
   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

   state_t           r_state;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_err;
   logic [EDW-1:0]   r_max;
   logic [SUM_W-1:0] r_sum;

   logic             w_accept;
   logic             w_start;
   logic             w_upd;
   logic             w_drained;
   logic [EDW-1:0]   w_ed;
   logic [EDW-1:0]   w_ed_acc;

   assign w_accept = valid_i & r_ready;
   assign w_start  = start_i & (r_state != S_RUN);

   adder32_abs_diff #(
      .WIDTH (WIDTH)
   ) u_abs_diff (
      .i_add1   (add1_i),
      .i_add2   (add2_i),
      .i_result (result_i),
      .o_ed     (w_ed)
   );

`ifdef ADDER32_ERRMON_PIPE_EN
   logic           r_pipe_v;
   logic [EDW-1:0] r_pipe_ed;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pipe_v  <= 1'b0;
         r_pipe_ed <= '0;
      end else if (w_start) begin
         r_pipe_v  <= 1'b0;
         r_pipe_ed <= '0;
      end else begin
         r_pipe_v  <= w_accept;
         r_pipe_ed <= w_ed;
      end
   end

   assign w_upd     = r_pipe_v;
   assign w_ed_acc  = r_pipe_ed;
   assign w_drained = ~r_pipe_v;
`else
   assign w_upd     = w_accept;
   assign w_ed_acc  = w_ed;
   assign w_drained = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rem   <= '0;
         r_err   <= '0;
         r_max   <= '0;
         r_sum   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_rem   <= WIN_C;
                  r_err   <= '0;
                  r_max   <= '0;
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_rem <= r_rem - CNT_W'(1);
                  if (r_rem == CNT_W'(1))
                     r_ready <= 1'b0;
               end
               if (w_upd) begin
                  r_err <= r_err + CNT_W'(|w_ed_acc);
                  if (w_ed_acc > r_max)
                     r_max <= w_ed_acc;
                  r_sum <= SUM_W'(sat_add(64'(r_sum), 64'(w_ed_acc),
                                          SUM_W));
               end
               // Finish only once the last sample has reached the stats.
               if (r_rem == '0 && w_drained) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready_o     = r_ready;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign err_count_o = r_err;
   assign max_ed_o    = r_max;
   assign sum_ed_o    = r_sum;

endmodule

// File: tb/tb_adder32_error_monitor.sv
// tb_adder32_error_monitor: scoreboard bench for the error monitor,
// WINDOW=4/SUM_W=33 main instance plus a WINDOW=1 instance.
module tb_adder32_error_monitor;

   localparam int WIN = 4;
`ifdef ADDER32_ERRMON_PIPE_EN
   localparam int DONE_DLY = 2;
`else
   localparam int DONE_DLY = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [32:0] res = '0;
   logic        ready, busy, done;
   logic [2:0]  err;
   logic [32:0] maxed;
   logic [32:0] sumed;

   logic        start1 = 1'b0;
   logic        valid1 = 1'b0;
   logic        ready1, busy1, done1;
   logic [0:0]  err1;
   logic [32:0] max1;
   logic [47:0] sum1;

   always #5 clk = ~clk;

   adder32_error_monitor #(
      .WIDTH (32), .WINDOW (WIN), .SUM_W (33)
   ) u_dut (
      .clk_i (clk), .rst_ni (rst_n), .start_i (start),
      .valid_i (valid), .ready_o (ready),
      .add1_i (a), .add2_i (b), .result_i (res),
      .busy_o (busy), .done_o (done), .err_count_o (err),
      .max_ed_o (maxed), .sum_ed_o (sumed)
   );

   adder32_error_monitor #(
      .WIDTH (32), .WINDOW (1), .SUM_W (48)
   ) u_one (
      .clk_i (clk), .rst_ni (rst_n), .start_i (start1),
      .valid_i (valid1), .ready_o (ready1),
      .add1_i (a), .add2_i (b), .result_i (res),
      .busy_o (busy1), .done_o (done1), .err_count_o (err1),
      .max_ed_o (max1), .sum_ed_o (sum1)
   );

   typedef struct {
      int          err;
      logic [32:0] mx;
      logic [32:0] sm;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tot = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          last_acc = 0;
   logic [31:0] sa[WIN];
   logic [31:0] sb[WIN];
   logic [32:0] sr[WIN];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_tot++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [32:0] model_ed(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [32:0] r);
      logic [32:0] ex;
      ex = {1'b0, x} + {1'b0, y};
      return (ex >= r) ? ex - r : r - ex;
   endfunction

   function automatic logic [32:0] exact(input logic [31:0] x,
                                         input logic [31:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (valid && ready) begin
         n_acc    <= n_acc + 1;
         last_acc <= cyc + 1;
      end
   end

   task automatic set_exact(input int i, input logic [31:0] x,
                            input logic [31:0] y);
      sa[i] = x;
      sb[i] = y;
      sr[i] = exact(x, y);
   endtask

   task automatic run_win(input string tag, input bit gap,
                          input bit hold, input bit pre_v);
      exp_t        e;
      exp_t        w;
      logic [33:0] s;
      logic [32:0] ed;
      int          acc0;
      int          guard;
      e.err = 0;
      e.mx  = '0;
      s     = '0;
      for (int i = 0; i < WIN; i++) begin
         ed = model_ed(sa[i], sb[i], sr[i]);
         if (ed != 0) e.err++;
         if (ed > e.mx) e.mx = ed;
         s = s + {1'b0, ed};
         if (s > 34'h1_FFFF_FFFF) s = 34'h1_FFFF_FFFF;
      end
      e.sm = s[32:0];
      exp_q.push_back(e);

      @(negedge clk);
      start = 1'b1;
      if (pre_v) begin
         a = sa[0]; b = sb[0]; res = sr[0]; valid = 1'b1;
      end
      acc0 = n_acc;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ":clr_err"}, 64'(err), 64'd0);
      chk({tag, ":clr_max"}, 64'(maxed), 64'd0);
      chk({tag, ":clr_sum"}, 64'(sumed), 64'd0);
      chk({tag, ":busy"}, 64'(busy), 64'd1);
      chk({tag, ":done_lo"}, 64'(done), 64'd0);

      for (int i = 0; i < WIN; i++) begin
         if (gap && $urandom_range(0, 1) == 1) begin
            valid = 1'b0;
            @(negedge clk);
         end
         a = sa[i]; b = sb[i]; res = sr[i]; valid = 1'b1;
         guard = 0;
         while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) chk({tag, ":rdy_to"}, 64'(ready), 64'd1);
         @(negedge clk);
      end
      valid = hold;

      guard = 0;
      while (!done && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, ":done"}, 64'(done), 64'd1);
      chk({tag, ":lat"}, 64'(cyc - last_acc), 64'(DONE_DLY));
      chk({tag, ":nacc"}, 64'(n_acc - acc0), 64'(WIN));
      chk({tag, ":rdy_done"}, 64'(ready), 64'd0);
      chk({tag, ":busy_done"}, 64'(busy), 64'd0);
      w = exp_q.pop_front();
      chk({tag, ":err"}, 64'(err), 64'(w.err));
      chk({tag, ":max"}, 64'(maxed), 64'(w.mx));
      chk({tag, ":sum"}, 64'(sumed), 64'(w.sm));
      if (hold) begin
         repeat (3) @(negedge clk);
         chk({tag, ":hold_nacc"}, 64'(n_acc - acc0), 64'(WIN));
         chk({tag, ":hold_rdy"}, 64'(ready), 64'd0);
         chk({tag, ":hold_sum"}, 64'(sumed), 64'(w.sm));
         chk({tag, ":hold_err"}, 64'(err), 64'(w.err));
         valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      int guard;
      logic [32:0] ex;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_max", 64'(maxed), 64'd0);
      chk("rst_sum", 64'(sumed), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      valid = 1'b1;
      @(negedge clk);
      chk("idle_ready", 64'(ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      valid = 1'b0;

      for (int i = 0; i < WIN; i++)
         set_exact(i, 32'h1234_0000 * (i + 1), 32'h0F0F_1111 + i);
      run_win("t1", 1'b0, 1'b0, 1'b0);

      sa[0] = 32'h29AF_2430; sb[0] = 32'h7A1B_9ABC;
      sr[0] = 33'h0_A3CA_BEE7;
      for (int i = 1; i < WIN; i++)
         set_exact(i, 32'hDEAD_0000 + i, 32'h0000_BEEF);
      run_win("t2", 1'b0, 1'b0, 1'b0);
      chk("t2_max5", 64'(maxed), 64'd5);

      sa[0] = 32'hFFFF_FFFF; sb[0] = 32'h0000_0001; sr[0] = '0;
      for (int i = 1; i < WIN; i++)
         set_exact(i, 32'h8000_0000, 32'h8000_0000 + i);
      run_win("t3", 1'b0, 1'b0, 1'b0);
      chk("t3_max_carry", 64'(maxed), 64'h1_0000_0000);

      for (int i = 0; i < WIN; i++) begin
         sa[i] = 32'hFFFF_FFFF; sb[i] = 32'h0000_0001; sr[i] = '0;
      end
      run_win("t4", 1'b0, 1'b0, 1'b0);
      chk("t4_sat", 64'(sumed), 64'h1_FFFF_FFFF);

      for (int i = 0; i < WIN; i++) begin
         sa[i] = $urandom; sb[i] = $urandom;
         ex = exact(sa[i], sb[i]);
         sr[i] = (i % 2 == 1) ? ex ^ 33'($urandom_range(1, 255)) : ex;
      end
      run_win("t5", 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 32'hFFFF_FFFF; b = 32'h1; res = '0; valid = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", 64'(ready), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_err", 64'(err), 64'd0);
      chk("t6_rst_max", 64'(maxed), 64'd0);
      chk("t6_rst_sum", 64'(sumed), 64'd0);
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < WIN; i++)
         set_exact(i, 32'h0101_0101 * i, 32'h7777_0000);
      sr[2] = sr[2] + 33'd9;
      run_win("t6a", 1'b0, 1'b0, 1'b0);
      sa[0] = 32'h1000_0000; sb[0] = 32'h2000_0000; sr[0] = 33'h0_2FFF_FFF0;
      for (int i = 1; i < WIN; i++)
         set_exact(i, 32'h5555_5555, 32'h0000_0003 * i);
      run_win("t6b", 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      a = 32'hFFFF_FFFF; b = 32'h1; res = '0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_ready", 64'(ready1), 64'd1);
      valid1 = 1'b1;
      guard = 0;
      while (!done1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("w1_done", 64'(done1), 64'd1);
      chk("w1_err", 64'(err1), 64'd1);
      chk("w1_max", 64'(max1), 64'h1_0000_0000);
      chk("w1_sum", 64'(sum1), 64'h1_0000_0000);
      chk("w1_rdy_done", 64'(ready1), 64'd0);
      valid1 = 1'b0;

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
